// File: rtl/fifo_bank_sequencer_pkg.sv
// Shared types and FIFO-bank ctrl/resp bit positions for the feature FIFO bank sequencer.
// The FIFO bank uses the same index constants, so both sides agree on bus layout.
package fifo_bank_sequencer_pkg;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_CAP,
      F_PRESENT
   } feed_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ACCEPT,
      R_WRITE
   } res_state_t;

   // ctrl bus: {rd_en, wr_en}; resp bus: {empty, full}
   localparam int WR_EN = 0;
   localparam int RD_EN = 1;
   localparam int FULL  = 0;
   localparam int EMPTY = 1;

endpackage

// File: rtl/fifo_bank_sequencer_seq_result_path.sv
// Result path: accepts PE results one at a time and pushes each into the output-feature bank,
// holding the word while the bank reports full.
module seq_result_path
   import fifo_bank_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_BANKS  = 15,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              job_start_i,
   input  logic [CNT_WIDTH-1:0]              num_words_i,
   input  logic [2*DATA_WIDTH*NUM_BANKS-1:0] pe_res_i,
   input  logic                              pe_res_valid_i,
   output logic                              pe_res_ready_o,
   input  logic                              of_full_i,
   output logic                              of_wr_en_o,
   output logic [2*DATA_WIDTH*NUM_BANKS-1:0] wr_of_data_o,
   output logic                              idle_next_o,
   output logic [1:0]                        state_o
);

   localparam int OW = 2*DATA_WIDTH*NUM_BANKS;

   res_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] written_q, written_d;
   logic [OW-1:0]        data_q, data_d;

   always_comb begin
      state_d    = state_q;
      written_d  = written_q;
      data_d     = data_q;
      of_wr_en_o = 1'b0;
      case (state_q)
         R_IDLE: begin
            if (job_start_i) begin
               written_d = '0;
               state_d   = R_ACCEPT;
            end
         end
         R_ACCEPT: begin
            if (pe_res_valid_i) begin
               data_d  = pe_res_i;
               state_d = R_WRITE;
            end
         end
         R_WRITE: begin
            // a full bank simply parks us here, which also withholds pe_res_ready_o
            if (!of_full_i) begin
               of_wr_en_o = 1'b1;
               written_d  = written_q + CNT_WIDTH'(1);
               state_d    = (written_d == num_words_i) ? R_IDLE : R_ACCEPT;
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= R_IDLE;
         written_q <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         written_q <= written_d;
         data_q    <= data_d;
      end
   end

   assign pe_res_ready_o = (state_q == R_ACCEPT);
   assign wr_of_data_o   = data_q;
   assign idle_next_o    = (state_d == R_IDLE);
   assign state_o        = state_q;

endmodule

// File: rtl/fifo_bank_sequencer.sv
// Initiator-side sequencer: drains the input-feature bank into the PE array and
// writes PE results into the output-feature bank for a host-programmed word count.
module fifo_bank_sequencer
   import fifo_bank_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_BANKS  = 15,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [CNT_WIDTH-1:0]              num_words,
   output logic                              busy,
   output logic                              done,
   output logic [1:0]                        if_fifo_ctrl,
   input  logic [1:0]                        if_fifo_resp,
   input  logic [DATA_WIDTH*NUM_BANKS-1:0]   rd_if_data_i,
   output logic [DATA_WIDTH*NUM_BANKS-1:0]   pe_data_o,
   output logic                              pe_valid_o,
   input  logic                              pe_ready_i,
   input  logic [2*DATA_WIDTH*NUM_BANKS-1:0] pe_res_i,
   input  logic                              pe_res_valid_i,
   output logic                              pe_res_ready_o,
   output logic [1:0]                        of_fifo_ctrl,
   input  logic [1:0]                        of_fifo_resp,
   output logic [2*DATA_WIDTH*NUM_BANKS-1:0] wr_of_data_o
);

   localparam int IW = DATA_WIDTH*NUM_BANKS;

   feed_state_t          feed_q, feed_d;
   logic [CNT_WIDTH-1:0] issued_q, issued_d;
   logic [CNT_WIDTH-1:0] n_q;
   logic [IW-1:0]        pe_data_q, pe_data_d;
   logic                 busy_q, done_q;
   logic                 start_ok, job_start, rd_en, wr_en, res_idle_next;
   logic [1:0]           res_state_dbg;
   logic                 unused_resp;

   assign start_ok  = start && !busy_q;
   assign job_start = start_ok && (num_words != '0);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends on ready, and the offered word is held until the transfer.
   always_comb begin
      feed_d    = feed_q;
      issued_d  = issued_q;
      pe_data_d = pe_data_q;
      rd_en     = 1'b0;
      case (feed_q)
         F_IDLE: begin
            if (job_start) begin
               issued_d = '0;
               feed_d   = F_REQ;
            end
         end
         F_REQ: begin
            if (!if_fifo_resp[EMPTY]) begin
               rd_en  = 1'b1;
               feed_d = F_CAP;
            end
         end
         F_CAP: begin
            pe_data_d = rd_if_data_i;
            feed_d    = F_PRESENT;
         end
         F_PRESENT: begin
            if (pe_ready_i) begin
               issued_d = issued_q + CNT_WIDTH'(1);
               feed_d   = (issued_d == n_q) ? F_IDLE : F_REQ;
            end
         end
         default: feed_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         feed_q    <= F_IDLE;
         issued_q  <= '0;
         pe_data_q <= '0;
      end else begin
         feed_q    <= feed_d;
         issued_q  <= issued_d;
         pe_data_q <= pe_data_d;
      end
   end

   // done fires in the first cycle both paths read idle; a zero-length job skips straight to it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         n_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_ok) begin
            n_q    <= num_words;
            busy_q <= job_start;
            done_q <= !job_start;
         end else if (busy_q && (feed_d == F_IDLE) && res_idle_next) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   seq_result_path #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BANKS  (NUM_BANKS),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_res (
      .clk_i          (clk),
      .rst_ni         (rst),
      .job_start_i    (job_start),
      .num_words_i    (n_q),
      .pe_res_i       (pe_res_i),
      .pe_res_valid_i (pe_res_valid_i),
      .pe_res_ready_o (pe_res_ready_o),
      .of_full_i      (of_fifo_resp[FULL]),
      .of_wr_en_o     (wr_en),
      .wr_of_data_o   (wr_of_data_o),
      .idle_next_o    (res_idle_next),
      .state_o        (res_state_dbg)
   );

   always_comb begin
      if_fifo_ctrl        = '0;
      if_fifo_ctrl[RD_EN] = rd_en;
      of_fifo_ctrl        = '0;
      of_fifo_ctrl[WR_EN] = wr_en;
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pe_data_o   = pe_data_q;
   assign pe_valid_o  = (feed_q == F_PRESENT);
   assign unused_resp = ^{if_fifo_resp[FULL], of_fifo_resp[EMPTY], res_state_dbg};

endmodule

// File: tb/tb_fifo_bank_sequencer.sv
// Bench for fifo_bank_sequencer: behavioural input bank, 2-cycle echo PE and output-bank
// capture around a table of jobs, plus a hand-written mid-job reset sequence.
module tb_fifo_bank_sequencer;

   localparam int DW = 8;
   localparam int NB = 15;
   localparam int CW = 8;
   localparam int IW = DW*NB;
   localparam int OW = 2*DW*NB;

   typedef struct {
      int       n;
      int       preload;
      int       fill_at;
      int       full_lo;
      int       full_hi;
      logic [3:0] ready_mask;
      int       restart_at;
      int       exp_rd;
      int       exp_wr;
      int       exp_dones;
      int       exp_done_cyc;
   } vec_t;

   typedef struct {
      logic [OW-1:0] d;
      int            t;
   } res_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] num_words;
   logic          busy;
   logic          done;
   logic [1:0]    if_fifo_ctrl;
   logic [1:0]    if_fifo_resp;
   logic [IW-1:0] rd_if_data_i;
   logic [IW-1:0] pe_data_o;
   logic          pe_valid_o;
   logic          pe_ready_i;
   logic [OW-1:0] pe_res_i;
   logic          pe_res_valid_i;
   logic          pe_res_ready_o;
   logic [1:0]    of_fifo_ctrl;
   logic [1:0]    of_fifo_resp;
   logic [OW-1:0] wr_of_data_o;

   fifo_bank_sequencer #(
      .DATA_WIDTH (DW),
      .NUM_BANKS  (NB),
      .CNT_WIDTH  (CW)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .num_words      (num_words),
      .busy           (busy),
      .done           (done),
      .if_fifo_ctrl   (if_fifo_ctrl),
      .if_fifo_resp   (if_fifo_resp),
      .rd_if_data_i   (rd_if_data_i),
      .pe_data_o      (pe_data_o),
      .pe_valid_o     (pe_valid_o),
      .pe_ready_i     (pe_ready_i),
      .pe_res_i       (pe_res_i),
      .pe_res_valid_i (pe_res_valid_i),
      .pe_res_ready_o (pe_res_ready_o),
      .of_fifo_ctrl   (of_fifo_ctrl),
      .of_fifo_resp   (of_fifo_resp),
      .wr_of_data_o   (wr_of_data_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- bench state ----------------
   int checks   = 0;
   int failures = 0;

   vec_t          vecs[7];
   vec_t          cur;
   int            cur_job;
   int            rel;
   int            rd_cnt, wr_cnt, pe_cnt, done_cnt, done_rel, viol;
   logic [IW-1:0] if_q[$];
   res_t          pipe[$];
   logic [OW-1:0] out_q[$];
   logic [OW-1:0] exp_q[$];
   logic          pending;
   logic [OW-1:0] pend_val;
   logic          prev_stall;
   logic [IW-1:0] prev_pd;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] mk_word(input int job, input int k);
      logic [IW-1:0] w;
      for (int i = 0; i < NB; i++) w[i*DW +: DW] = DW'(job*37 + k*11 + i*5 + 200);
      return w;
   endfunction

   function automatic logic [OW-1:0] zext(input logic [IW-1:0] w);
      logic [OW-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) r[i*2*DW +: 2*DW] = {{DW{1'b0}}, w[i*DW +: DW]};
      return r;
   endfunction

   function automatic logic [IW-1:0] junk_iw();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[IW-1:0];
   endfunction

   function automatic logic [OW-1:0] junk_ow();
      logic [255:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return r[OW-1:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic load_if();
      for (int k = 0; k < cur.preload; k++) if_q.push_back(mk_word(cur_job, k));
   endtask

   task automatic drive_inputs();
      if_fifo_resp    = {(if_q.size() == 0), 1'b0};
      of_fifo_resp    = {1'b0, (rel >= cur.full_lo && rel <= cur.full_hi)};
      pe_ready_i      = cur.ready_mask[rel % 4];
      pe_res_valid_i  = (pipe.size() > 0) && (pipe[0].t <= rel);
      pe_res_i        = pe_res_valid_i ? pipe[0].d : junk_ow();
      if (rel == cur.restart_at) begin
         start     = 1'b1;
         num_words = '0;
      end else begin
         start     = 1'b0;
         num_words = CW'(cur.n);
      end
   endtask

   task automatic job_init(input vec_t v, input int job);
      cur     = v;
      cur_job = job;
      rel     = 0;
      rd_cnt = 0; wr_cnt = 0; pe_cnt = 0; done_cnt = 0; done_rel = -1; viol = 0;
      if_q.delete(); pipe.delete(); out_q.delete(); exp_q.delete();
      pending    = 1'b0;
      pend_val   = '0;
      prev_stall = 1'b0;
      prev_pd    = '0;
      for (int k = 0; k < v.preload; k++) exp_q.push_back(zext(mk_word(job, k)));
      if (v.fill_at == 0) load_if();
      rd_if_data_i = junk_iw();
      drive_inputs();
      start     = 1'b1;
      num_words = CW'(v.n);
   endtask

   // One clock: observe at the falling edge, then update the bank/PE models after the rising edge.
   task automatic cycle();
      logic          o_rd, o_wr, o_pe_hs, o_res_hs;
      logic [IW-1:0] o_pd;
      logic [OW-1:0] o_res_d;
      res_t          e;
      @(negedge clk);
      o_rd     = if_fifo_ctrl[1];
      o_wr     = of_fifo_ctrl[0];
      o_pe_hs  = pe_valid_o && pe_ready_i;
      o_pd     = pe_data_o;
      o_res_hs = pe_res_valid_i && pe_res_ready_o;
      o_res_d  = pe_res_i;
      if (if_fifo_ctrl[0] || of_fifo_ctrl[1]) viol++;
      if (o_rd && if_fifo_resp[1]) viol++;
      if (o_wr && of_fifo_resp[0]) viol++;
      if (pending && (pe_res_ready_o || wr_of_data_o !== pend_val)) viol++;
      if (prev_stall && (!pe_valid_o || pe_data_o !== prev_pd)) viol++;
      prev_stall = pe_valid_o && !pe_ready_i;
      prev_pd    = pe_data_o;
      if (o_rd) rd_cnt++;
      if (o_wr) begin
         wr_cnt++;
         out_q.push_back(wr_of_data_o);
      end
      if (o_pe_hs) pe_cnt++;
      if (done) begin
         if (done_cnt == 0) done_rel = rel;
         done_cnt++;
         if (busy) viol++;
      end
      @(posedge clk);
      #1;
      rel++;
      if (o_wr) pending = 1'b0;
      if (o_res_hs) begin
         pending  = 1'b1;
         pend_val = o_res_d;
         if (pipe.size() > 0) pipe.delete(0);
      end
      if (o_pe_hs) begin
         e.d = zext(o_pd);
         e.t = rel + 1;
         pipe.push_back(e);
      end
      if (cur.fill_at > 0 && rel == cur.fill_at) load_if();
      if (o_rd && if_q.size() > 0) rd_if_data_i = if_q.pop_front();
      else                         rd_if_data_i = junk_iw();
      drive_inputs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl_bits"}, 256'({busy, done, pe_valid_o, pe_res_ready_o, if_fifo_ctrl, of_fifo_ctrl}), 256'(0));
      check({tag, "_pe_data"}, 256'(pe_data_o), 256'(0));
      check({tag, "_wr_data"}, 256'(wr_of_data_o), 256'(0));
   endtask

   // ---------------- scoreboard / job runner ----------------
   task automatic run_job(input vec_t v, input int job);
      string tag;
      tag = $sformatf("job%0d", job);
      job_init(v, job);
      cycle();
      check({tag, "_busy_after_start"}, 256'(busy), 256'(v.n != 0));
      while (done_cnt == 0 && rel < 300) cycle();
      repeat (2) cycle();
      check({tag, "_done_pulses"}, 256'(done_cnt), 256'(v.exp_dones));
      if (v.exp_done_cyc >= 0) check({tag, "_done_cycle"}, 256'(done_rel), 256'(v.exp_done_cyc));
      check({tag, "_rd_en_pulses"}, 256'(rd_cnt), 256'(v.exp_rd));
      check({tag, "_wr_en_pulses"}, 256'(wr_cnt), 256'(v.exp_wr));
      check({tag, "_issued"}, 256'(pe_cnt), 256'(v.n));
      check({tag, "_protocol_viol"}, 256'(viol), 256'(0));
      check({tag, "_busy_end"}, 256'(busy), 256'(0));
      check({tag, "_out_words"}, 256'(out_q.size()), 256'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
         check($sformatf("%s_out%0d", tag, k), 256'(out_q[k]), 256'(exp_q[k]));
   endtask

   // ---------------- test ----------------
   initial begin
      vec_t rv;
      int   rst_done;
      //           n pre fill flo fhi  mask     rst  rd wr dn dcyc
      vecs[0] = '{4, 4,  0,  -1, -1, 4'b1111, -1, 4, 4, 1, 16};  // basic job
      vecs[1] = '{2, 2,  10, -1, -1, 4'b1111, -1, 2, 2, 1, -1};  // input bank empty for 10 cycles
      vecs[2] = '{3, 3,  0,  5,  12, 4'b1111, -1, 3, 3, 1, -1};  // output bank full 5..12
      vecs[3] = '{3, 3,  0,  -1, -1, 4'b1001, -1, 3, 3, 1, -1};  // pe_ready 1,0,0,1
      vecs[4] = '{0, 0,  0,  -1, -1, 4'b1111, -1, 0, 0, 1, 1};   // zero-length job
      vecs[5] = '{3, 3,  0,  -1, -1, 4'b1111, 4,  3, 3, 1, -1};  // start while busy ignored
      vecs[6] = '{1, 1,  0,  -1, -1, 4'b1111, -1, 1, 1, 1, -1};  // job after mid-job reset

      rst            = 1'b0;
      start          = 1'b0;
      num_words      = '0;
      if_fifo_resp   = 2'b10;
      of_fifo_resp   = 2'b00;
      rd_if_data_i   = '0;
      pe_ready_i     = 1'b0;
      pe_res_i       = '0;
      pe_res_valid_i = 1'b0;
      cur            = vecs[0];
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      for (int j = 0; j < 6; j++) run_job(vecs[j], j);

      // mid-job reset while a result waits in R_WRITE against a full output bank
      rv = '{2, 2, 0, 0, 1000, 4'b1111, -1, 0, 0, 0, -1};
      job_init(rv, 7);
      cycle();
      while (!pending && rel < 60) cycle();
      check("rstseq_wr_pending", 256'(pending), 256'(1));
      rst = 1'b0;
      #1;
      check_all_zero("rstseq_async");
      start    = 1'b0;
      rst_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) rst_done++;
      end
      check("rstseq_no_done", 256'(rst_done), 256'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_job(vecs[6], 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_bank_sequencer.md
Name: fifo_bank_sequencer

Overview:
- Initiator-side controller for the input-feature and output-feature FIFO bank.
- Drains the input-feature FIFO bank lane-parallel (NUM_BANKS lanes) and presents each word to the PE array over a valid/ready handshake.
- Accepts PE results over a valid/ready handshake and pushes them into the output-feature FIFO bank.
- Drives the bank's ctrl buses ({rd_en, wr_en}) and obeys its resp buses ({empty, full}) for a host-programmed word count.

Parameters:
DATA_WIDTH, 8, input-feature lane width; output lanes are 2*DATA_WIDTH
NUM_BANKS, 15, number of parallel lanes
CNT_WIDTH, 8, width of the word counters and num_words

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle job start; sampled only when busy=0
num_words  input  CNT_WIDTH  words per job, latched on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
if_fifo_ctrl  output  2  [0]=wr_en (tied 0), [1]=rd_en to input-feature bank
if_fifo_resp  input  2  [0]=full (unused), [1]=empty
rd_if_data_i  input  DATA_WIDTH x NUM_BANKS  input-feature bank read data, valid 1 cycle after rd_en
pe_data_o  output  DATA_WIDTH x NUM_BANKS  operand word to PE array
pe_valid_o  output  1  operand valid
pe_ready_i  input  1  PE array accepts operand
pe_res_i  input  2*DATA_WIDTH x NUM_BANKS  PE result word
pe_res_valid_i  input  1  result valid
pe_res_ready_o  output  1  sequencer accepts result
of_fifo_ctrl  output  2  [0]=wr_en to output-feature bank, [1]=rd_en (tied 0)
of_fifo_resp  input  2  [0]=full, [1]=empty (unused)
wr_of_data_o  output  2*DATA_WIDTH x NUM_BANKS  write data to output-feature bank

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - Both FSMs go to IDLE; counters, pe_data_o and wr_of_data_o clear to 0.
  - busy, done, pe_valid_o, pe_res_ready_o and all ctrl bits = 0.
  - A job in progress is abandoned with no done pulse.
- Accepted start (start=1 and busy=0):
  - Latch num_words into N; clear issued/written counters.
  - busy=1 next cycle; both FSMs leave IDLE.
  - start while busy=1 is ignored.
- N=0: no FIFO or PE traffic; done pulses the cycle after start; busy drops with done.
- Feed FSM (F_IDLE, F_REQ, F_CAP, F_PRESENT):
  - F_REQ: if if_fifo_resp[1]=0, drive if_fifo_ctrl[1]=1 for exactly one cycle and go to F_CAP. If empty, stay and wait indefinitely.
  - F_CAP: register rd_if_data_i into pe_data_o; go to F_PRESENT.
  - F_PRESENT: pe_valid_o=1; pe_data_o held stable until pe_ready_i=1.
  - On handshake: issued++. If issued==N go to F_IDLE (feed complete), else go to F_REQ.
  - Max throughput is one operand per 3 cycles; at most one read is ever in flight.
- Result FSM (R_IDLE, R_ACCEPT, R_WRITE):
  - R_ACCEPT: pe_res_ready_o=1; on pe_res_valid_i=1, register pe_res_i into wr_of_data_o and go to R_WRITE.
  - R_WRITE: pe_res_ready_o=0. If of_fifo_resp[0]=0, drive of_fifo_ctrl[0]=1 for one cycle and written++. Then go to R_IDLE if written==N, else R_ACCEPT.
  - If full, hold wr_of_data_o and stay in R_WRITE (backpressure to the PE array).
- FSM independence:
  - The two FSMs run independently; results may arrive before all operands are issued.
  - Results arriving while the result FSM is in R_IDLE are not accepted (pe_res_ready_o=0).
- Completion:
  - done=1 for one cycle in the cycle after both FSMs have returned to IDLE within a job.
  - busy=0 the same cycle done=1.
- Counter width: counters are CNT_WIDTH with no wrap within a job, since N < 2^CNT_WIDTH by construction.
- Invariants: if_fifo_ctrl[0] and of_fifo_ctrl[1] are always 0. Never read on empty; never write on full.

Decomposition:
- Shared package: feed_state_t and res_state_t enums, and ctrl/resp bit-index constants (WR_EN=0, RD_EN=1, FULL=0, EMPTY=1). The FIFO bank and this block share the index constants.
- One natural sub-module, seq_result_path: the result FSM, wr_of_data_o register and written counter.
- Feed FSM, job control and done/busy stay in the top.

Test Plan:
- Basic job: N=4, input FIFO preloaded with 4 words, pe_ready_i=1, PE echoes each operand zero-extended after 2 cycles -> exactly 4 rd_en pulses and 4 wr_en pulses; output bank holds the 4 words in order; one done pulse; busy low afterwards.
- Empty stall: N=2, input FIFO empty for 10 cycles then filled -> rd_en stays 0 while empty=1; job completes normally after the fill.
- Full backpressure: N=3, of full=1 for cycles 5-12 -> wr_en=0 and wr_of_data_o stable while full; pe_res_ready_o=0; all 3 words are written after full drops.
- PE backpressure: pe_ready_i toggled 1,0,0,1 -> pe_data_o stable while pe_valid_o=1 and ready=0; issued count exact.
- Edge cases: N=0 -> done the cycle after start with zero ctrl activity. start asserted while busy -> ignored.
- Mid-job reset: rst=0 during R_WRITE with wr_en pending -> all outputs 0 immediately; no done pulse; a new start with N=1 then completes correctly.
